// File: rtl/fir_decim_fifo_if.sv
// Handshake bundle between the FIR decimator/FIFO stage and its consumer.
// The stage drives the slave side. The testbench or framer drives the master side.
interface fir_decim_fifo_if #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 8
);
   logic                          CLR;
   logic signed [DATA_W-1:0]      IN_DATA;
   logic signed [DATA_W-1:0]      OUT_DATA;
   logic                          OUT_VALID;
   logic                          OUT_READY;
   logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT;
   logic                          OVERFLOW;

   modport master (
      output CLR, IN_DATA, OUT_READY,
      input  OUT_DATA, OUT_VALID, FIFO_COUNT, OVERFLOW
   );

   modport slave (
      input  CLR, IN_DATA, OUT_READY,
      output OUT_DATA, OUT_VALID, FIFO_COUNT, OVERFLOW
   );
endinterface

// File: rtl/fir_decim_fifo.sv
// FIR output stage. It skips the FIR warm-up samples and averages DECIM samples with rounding.
// Each result goes into a show-ahead FIFO with a valid/ready handshake toward the consumer.
module fir_decim_fifo #(
   parameter int DATA_W     = 16,
   parameter int DECIM      = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int WARMUP     = 14
) (
   input  logic             CLK,
   input  logic             RSTN,
   fir_decim_fifo_if.slave  bus
);
   localparam int L     = $clog2(DECIM);
   localparam int ACC_W = DATA_W + L;
   localparam int PH_W  = (L > 0) ? L : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WC_W  = $clog2(WARMUP + 1);
   localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(DECIM / 2);

   typedef enum logic {S_WARM, S_RUN} state_t;

   state_t                   state, state_nxt;
   logic [WC_W-1:0]          warm_cnt;
   logic                     warm_inc;

   logic signed [ACC_W-1:0]  acc_p0, acc_nxt, din_ext;
   logic [PH_W-1:0]          phase_p0;
   logic                     last, push;
   logic signed [DATA_W-1:0] res;

   logic signed [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [CNT_W-1:0]         count;
   logic                     ovf, full, empty, pop, wr_en, ovf_set;

   // Rounds half toward +inf. The extra guard bit absorbs the +HALF at full scale.
   function automatic logic signed [DATA_W-1:0] round_avg(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W:0] t;
      t = (ACC_W+1)'(a) + HALF;
      t = t >>> L;
      return t[DATA_W-1:0];
   endfunction

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state    <= S_WARM;
         warm_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (warm_inc) warm_cnt <= warm_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      warm_inc  = 1'b0;
      case (state)
         S_WARM: begin
            warm_inc = 1'b1;
            if (warm_cnt == WC_W'(WARMUP - 1)) state_nxt = S_RUN;
         end
         default: ;
      endcase
   end

   // p0: accumulate the decimation group. The result is produced on the group's last sample.
   always_comb begin
      din_ext = ACC_W'(bus.IN_DATA);
      last    = (phase_p0 == PH_W'(DECIM - 1));
      acc_nxt = (phase_p0 == '0) ? din_ext : acc_p0 + din_ext;
      res     = round_avg(acc_nxt);
      push    = (state == S_RUN) && last && !bus.CLR;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         acc_p0   <= '0;
         phase_p0 <= '0;
      end else if (bus.CLR) begin
         acc_p0   <= '0;
         phase_p0 <= '0;
      end else if (state == S_RUN) begin
         acc_p0   <= acc_nxt;
         phase_p0 <= last ? '0 : phase_p0 + 1'b1;
      end
   end

   // A pop frees a slot on the same edge, so a full FIFO still accepts a push when it is read.
   always_comb begin
      full    = (count == CNT_W'(FIFO_DEPTH));
      empty   = (count == '0);
      pop     = !empty && bus.OUT_READY && !bus.CLR;
      wr_en   = push && (!full || pop);
      ovf_set = push && full && !pop;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else if (bus.CLR) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !pop)      count <= count + 1'b1;
         else if (pop && !wr_en) count <= count - 1'b1;
         if (ovf_set) ovf <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr] <= res;
   end

   assign bus.OUT_VALID  = !empty;
   assign bus.OUT_DATA   = empty ? '0 : mem[rd_ptr];
   assign bus.FIFO_COUNT = count;
   assign bus.OVERFLOW   = ovf;
endmodule
